// File: rtl/cmd_assembler_if.sv
// Byte-in / command-out bundle between a UART receiver, the assembler and its consumer.
// Latency: n/a (wiring only).
// Backpressure: clr_rdy acknowledges bytes upstream, clr_cmd_rdy releases the held command.
interface cmd_assembler_if;
  logic [7:0]  rx_data;
  logic        rdy;
  logic        clr_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        tmo;

  // Assembler side: consumes bytes, produces commands
  modport slave (
    input  rx_data, rdy, clr_cmd_rdy,
    output clr_rdy, cmd, cmd_rdy, tmo
  );

  // Environment side: produces bytes, consumes commands
  modport master (
    output rx_data, rdy, clr_cmd_rdy,
    input  clr_rdy, cmd, cmd_rdy, tmo
  );
endinterface

// File: rtl/cmd_assembler.sv
// Assembles three received bytes into a 24-bit command, dropping partial commands on idle timeout.
// Latency: byte accepted in cycle N -> clr_rdy in N+1; third byte in N -> cmd/cmd_rdy valid in N+1.
// Backpressure: while a finished command is unconsumed in IDLE, rdy is ignored and the byte is held upstream.
module cmd_assembler #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic             clk,
  input logic             rst_n,
  cmd_assembler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    MID  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_byte0;
  logic [7:0]  r_byte1;
  logic [23:0] r_cmd;
  logic        r_cmd_rdy;
  logic        r_clr_rdy;
  logic        r_tmo;
  logic [15:0] r_cnt;

  logic        w_in_idle;
  logic        w_accept;
  logic        w_tmo_hit;
  logic        w_complete;

  // The spare encoding behaves exactly like IDLE so the FSM always recovers.
  assign w_in_idle = (r_state != HIGH) && (r_state != MID);

  // rdy is still high in the acknowledge cycle, so that cycle is skipped to avoid
  // taking the same byte twice; a pending command blocks the start of a new one.
  assign w_accept   = bus.rdy & ~r_clr_rdy & ~(w_in_idle & r_cmd_rdy);
  assign w_complete = w_accept & (r_state == MID);

  // Next-state selection; accept wins over an expiring timeout
  always_comb begin
    w_state_nxt = IDLE;
    w_tmo_hit   = 1'b0;
    case (r_state)
      HIGH: begin
        if (w_accept) begin
          w_state_nxt = MID;
        end else if (r_cnt == TIMEOUT - 16'd1) begin
          w_state_nxt = IDLE;
          w_tmo_hit   = 1'b1;
        end else begin
          w_state_nxt = HIGH;
        end
      end
      MID: begin
        if (w_accept) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == TIMEOUT - 16'd1) begin
          w_state_nxt = IDLE;
          w_tmo_hit   = 1'b1;
        end else begin
          w_state_nxt = MID;
        end
      end
      default: begin
        w_state_nxt = w_accept ? HIGH : IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Held bytes of the partial command; wiped when the command times out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
    end else if (w_tmo_hit) begin
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
    end else if (w_accept) begin
      if (w_in_idle) begin
        r_byte0 <= bus.rx_data;
      end
      if (r_state == HIGH) begin
        r_byte1 <= bus.rx_data;
      end
    end
  end

  // Completed command and its ready flag; a completion beats a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= 24'h000000;
      r_cmd_rdy <= 1'b0;
    end else if (w_complete) begin
      r_cmd     <= {r_byte0, r_byte1, bus.rx_data};
      r_cmd_rdy <= 1'b1;
    end else if (bus.clr_cmd_rdy) begin
      r_cmd_rdy <= 1'b0;
    end
  end

  // One-cycle acknowledge and timeout pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_rdy <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_clr_rdy <= w_accept;
      r_tmo     <= w_tmo_hit;
    end
  end

  // Inter-byte idle counter; only runs while a command is partially received
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (w_accept || w_in_idle || w_tmo_hit) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.clr_rdy = r_clr_rdy;
  assign bus.cmd     = r_cmd;
  assign bus.cmd_rdy = r_cmd_rdy;
  assign bus.tmo     = r_tmo;

endmodule

// File: tb/tb_cmd_assembler.sv
// Self-checking bench for cmd_assembler: table of commands plus hand-written corner sequences.
// Commands are checked through an expected-value queue popped on each cmd_rdy rising edge.
// Inputs are driven 1 time unit after posedge; outputs are observed at negedge or after posedge+1.
module tb_cmd_assembler;

  localparam logic [15:0] TMO = 16'd16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cmd_assembler_if bus();

  cmd_assembler #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    bit          hold2;
    logic [23:0] exp_cmd;
  } vec_t;

  vec_t        vecs[4];
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_clr  = 0;
  int          n_tmo  = 0;
  logic        prev_cmd_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output monitor: counts pulses and scores completed commands
  always @(negedge clk) begin
    if (bus.clr_rdy) n_clr++;
    if (bus.tmo) n_tmo++;
    if (bus.cmd_rdy && !prev_cmd_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got %h, expected no command", bus.cmd);
      end else begin
        chk("cmd", {8'h00, bus.cmd}, {8'h00, exp_q.pop_front()});
      end
    end
    prev_cmd_rdy = bus.cmd_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold2=0: keep rdy until clr_rdy is seen; hold2=1: rdy high for exactly two cycles
  task automatic send_byte(input logic [7:0] d, input bit hold2);
    bus.rx_data = d;
    bus.rdy = 1'b1;
    if (hold2) begin
      tick();
      tick();
    end else begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!bus.clr_rdy && n < 60);
      if (!bus.clr_rdy) begin
        checks++;
        errors++;
        $display("FAIL clr_rdy_wait: got no clr_rdy, expected one within 60 cycles");
      end
    end
    bus.rdy = 1'b0;
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!bus.cmd_rdy && n < 60) begin
      tick();
      n++;
    end
    if (!bus.cmd_rdy) begin
      checks++;
      errors++;
      $display("FAIL cmd_rdy_wait: got cmd_rdy=0, expected 1 within 60 cycles");
    end
  endtask

  task automatic clear_cmd();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_cleared", {31'd0, bus.cmd_rdy}, 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input bit hold2, input logic [23:0] exp_cmd);
    int c0 = n_clr;
    exp_q.push_back(exp_cmd);
    send_byte(b0, hold2);
    send_byte(b1, hold2);
    send_byte(b2, hold2);
    wait_cmd();
    clear_cmd();
    chk("clr_rdy_pulses", n_clr - c0, 32'd3);
  endtask

  initial begin
    int bad;
    int n;
    int t0;
    bus.rx_data     = 8'h00;
    bus.rdy         = 1'b0;
    bus.clr_cmd_rdy = 1'b0;

    vecs[0] = '{b0: 8'hA5, b1: 8'h3C, b2: 8'h0F, hold2: 1'b0, exp_cmd: 24'hA53C0F};
    vecs[1] = '{b0: 8'h12, b1: 8'h34, b2: 8'h56, hold2: 1'b1, exp_cmd: 24'h123456};
    vecs[2] = '{b0: 8'hFF, b1: 8'h00, b2: 8'h80, hold2: 1'b0, exp_cmd: 24'hFF0080};
    vecs[3] = '{b0: 8'h00, b1: 8'hFF, b2: 8'h01, hold2: 1'b1, exp_cmd: 24'h00FF01};

    // Reset state
    #12;
    chk("rst_clr_rdy", {31'd0, bus.clr_rdy}, 32'd0);
    chk("rst_cmd", {8'h00, bus.cmd}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("rst_tmo", {31'd0, bus.tmo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table of commands, both rdy styles
    for (int i = 0; i < 4; i++) begin
      run_cmd(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].hold2, vecs[i].exp_cmd);
      repeat (2) tick();
    end

    // Backpressure: pending command blocks byte 8'h11 until consumed
    exp_q.push_back(24'hAABBCC);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    wait_cmd();
    bus.rx_data = 8'h11;
    bus.rdy = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.clr_rdy) bad++;
    end
    chk("bp_no_clr_rdy", bad, 32'd0);
    chk("bp_cmd_held", {8'h00, bus.cmd}, 32'h00AABBCC);
    chk("bp_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    exp_q.push_back(24'h112233);
    clear_cmd();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    wait_cmd();
    clear_cmd();
    repeat (2) tick();

    // Timeout: one byte then silence
    t0 = n_tmo;
    send_byte(8'h77, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.tmo && n < 40);
    chk("tmo_delay", n, 32'd16);
    tick();
    chk("tmo_one_cycle", {31'd0, bus.tmo}, 32'd0);
    chk("tmo_cmd_kept", {8'h00, bus.cmd}, 32'h00112233);
    chk("tmo_cmd_rdy_kept", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("tmo_count", n_tmo - t0, 32'd1);
    run_cmd(8'h01, 8'h02, 8'h03, 1'b0, 24'h010203);
    repeat (2) tick();

    // Byte arriving in the last allowed idle cycle is accepted
    t0 = n_tmo;
    exp_q.push_back(24'h445566);
    send_byte(8'h44, 1'b0);
    repeat (15) tick();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    wait_cmd();
    clear_cmd();
    repeat (20) tick();
    chk("edge_no_tmo", n_tmo - t0, 32'd0);

    // Asynchronous reset in MID discards the partial command
    send_byte(8'h9A, 1'b0);
    send_byte(8'h9B, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clr_rdy", {31'd0, bus.clr_rdy}, 32'd0);
    chk("mid_rst_cmd", {8'h00, bus.cmd}, 32'd0);
    chk("mid_rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("mid_rst_tmo", {31'd0, bus.tmo}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_cmd(8'hC1, 8'hC2, 8'hC3, 1'b0, 24'hC1C2C3);
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("tmo_total", n_tmo, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_assembler.md
CMD_ASSEMBLER -- requirements
Module: cmd_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000, meaning the maximum idle clk cycles allowed between bytes of one command.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its posedge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_data, input, 8, the received byte from the upstream UART receiver, valid while rdy=1.
REQ-005 SHALL have port rdy, input, 1, upstream byte-available flag.
REQ-006 SHALL have port clr_rdy, output, 1, registered one-cycle pulse to the receiver acknowledging the byte.
REQ-007 SHALL have port cmd, output, 24, the assembled command; the first byte is in cmd[23:16] and the last in cmd[7:0].
REQ-008 SHALL have port cmd_rdy, output, 1, flag meaning cmd holds a complete, unconsumed command.
REQ-009 SHALL have port clr_cmd_rdy, input, 1, consumer acknowledge that clears cmd_rdy.
REQ-010 SHALL have port tmo, output, 1, registered one-cycle pulse when a partial command is discarded on timeout.

Function
REQ-011 SHALL implement an FSM with states IDLE (awaiting byte 0), HIGH (byte 0 held, awaiting byte 1) and MID (bytes 0-1 held, awaiting byte 2).
REQ-012 SHALL define accept = rdy & ~clr_rdy & ~(state==IDLE & cmd_rdy).
REQ-013 SHALL, so that a byte whose rdy has not yet dropped is not taken twice, ignore rdy during the cycle clr_rdy is high.
REQ-014 SHALL, on accept, capture rx_data and assert clr_rdy for exactly the next cycle.
REQ-015 SHALL, on accept in IDLE, store the byte as byte 0 and go to HIGH.
REQ-016 SHALL, on accept in HIGH, store the byte as byte 1 and go to MID.
REQ-017 SHALL, on accept in MID, load cmd with {byte0, byte1, rx_data}, set cmd_rdy and go to IDLE; both updates become visible the following cycle.
REQ-018 SHALL apply backpressure while cmd_rdy=1 in IDLE: rdy is not accepted and clr_rdy is not pulsed, so the upstream byte is held.
REQ-019 SHALL hold cmd stable from completion until the next completion; cmd is not altered while cmd_rdy=1.
REQ-020 SHALL clear cmd_rdy on clr_cmd_rdy; if completion and clr_cmd_rdy coincide, set has priority.
REQ-021 SHALL maintain a 16-bit timeout counter that clears on every accept and in IDLE, and increments by 1 each cycle in HIGH or MID without accept.
REQ-022 SHALL, when the counter equals TIMEOUT-1 in HIGH or MID with no accept that cycle, go to IDLE, discard held bytes, clear the counter and pulse tmo the next cycle.
REQ-023 SHALL, when accept and timeout coincide, treat the accept as taking priority (no tmo, normal transition).
REQ-024 SHALL leave cmd and cmd_rdy unchanged by a timeout.
REQ-025 SHALL treat any unreachable state encoding as IDLE.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state=IDLE, cmd=24'h000000, cmd_rdy=0, clr_rdy=0, tmo=0, held bytes=0 and counter=0, irrespective of clk.
REQ-027 SHALL, on reset asserted mid-command, discard the partial command; after release, the next accepted byte is byte 0.

Verification
REQ-028 SHALL cover: bytes 8'hA5, 8'h3C, 8'h0F with rdy held until clr_rdy -> cmd=24'hA53C0F, cmd_rdy=1, exactly three clr_rdy pulses.
REQ-029 SHALL cover: rdy held high 2 cycles per byte -> each byte captured once, with no duplicate in cmd.
REQ-030 SHALL cover: cmd_rdy=1 with a new byte 8'h11 pending -> clr_rdy stays 0 until clr_cmd_rdy; 8'h11 is then captured as byte 0.
REQ-031 SHALL cover: TIMEOUT=16, one byte then silence -> tmo pulses 16 cycles after the accept; the next three bytes 01,02,03 give cmd=24'h010203.
REQ-032 SHALL cover: a byte arriving on exactly the TIMEOUT-1 cycle -> accepted, no tmo.
REQ-033 SHALL cover: rst_n pulsed low in MID -> all outputs 0 immediately; three new bytes then form a fresh command.
